piso_shift_serializer: RTL

//   Parallel-in, serial-out shift register with selectable bit order: the transmit-side

---
 rtl/piso_shift_serializer.sv | 63 ++++++
 1 files changed

// File: rtl/piso_shift_serializer.sv
// piso_shift_serializer: parallel-in, serial-out shifter with a valid/ready load handshake,
// per-word MSB/LSB-first order, en-driven stall, and a one-cycle done pulse after each frame.
module piso_shift_serializer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_dir,
   input  logic             en,
   output logic             q,
   output logic             q_valid,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t          state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             dir_r, dir_n, done_n, last, accept;
   always_comb begin
      last       = state == SHIFT && en && cnt == LAST;
      load_ready = state == IDLE || last;
      accept     = load_valid && load_ready;
      state_n    = state;
      sreg_n     = sreg;
      cnt_n      = cnt;
      dir_n      = dir_r;
      done_n     = last;
      if (accept) begin
         state_n = SHIFT;
         sreg_n  = load_data;
         cnt_n   = '0;
         dir_n   = load_dir;
      end else if (last) begin
         state_n = IDLE;
      end else if (state == SHIFT && en) begin
         sreg_n = dir_r ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
         cnt_n  = cnt + 1'b1;
      end
   end
   // sreg keeps its stale last bit after a frame ends, so q is gated by state
   assign q_valid = state == SHIFT;
   assign q       = q_valid && (dir_r ? sreg[0] : sreg[WIDTH-1]);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
         dir_r <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         sreg  <= sreg_n;
         cnt   <= cnt_n;
         dir_r <= dir_n;
         done  <= done_n;
      end
   end
endmodule
